// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
//   Shared definitions for the seven-segment scan controller:
//   digit count, segment bus type, the all-off pattern and the hex-to-segment table.
//   Segment bus layout: [7:1] = a..g, [0] = dp, all active low (1 = off).
package sevenseg_pkg;

  localparam int NUM_DIGITS = 3;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // a..g patterns for hex digits 0..F, active low (0 = segment on).
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/sevenseg_hex_dec.sv
// sevenseg_hex_dec
//   Combinational hex nibble + decimal point to active-low segment pattern.
//   Ports:
//     nibble  in  4  hex digit value
//     dp      in  1  decimal point, 1 = lit
//     seg     out 8  [7:1] = a..g, [0] = dp, active low
module sevenseg_hex_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg
);

  assign seg = {HEX_SEG[nibble], ~dp};

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//   Time-multiplexed scan controller for a 3-digit common-anode seven-segment display.
//   Holds a 3-nibble hex value plus 3 decimal points, cycles the active-low digit
//   enables with a blanking gap at the start of each dwell, and drives the matching
//   active-low segment pattern. New values commit only at a frame boundary so the
//   display never tears.
//   Ports:
//     clk        in   1   system clock, rising edge
//     rst_n      in   1   asynchronous active-low reset
//     scan_en    in   1   1 = scanning, 0 = display blanked
//     wr_valid   in   1   new display value offered
//     wr_ready   out  1   a value can be accepted (nothing pending)
//     wr_data    in   12  [3:0] digit0 (rightmost), [7:4] digit1, [11:8] digit2
//     wr_dp      in   3   decimal point per digit, 1 = lit
//     seg        out  8   [7:1] = a..g, [0] = dp, active low
//     seg_en     out  3   digit enables, active low (bit k = 0 selects digit k)
//     frame_tick out  1   pulse on the last cycle of the digit-2 dwell
//   Build option: define SEVSEG_LZB_EN for leading-zero blanking of digits 2 and 1.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int DIV_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scan_en,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  input  logic [NUM_DIGITS-1:0]     wr_dp,
  output seg_t                      seg,
  output logic [NUM_DIGITS-1:0]     seg_en,
  output logic                      frame_tick
);

  localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_BLANK = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0]          cnt;
  logic [1:0]                idx;
  logic [4*NUM_DIGITS-1:0]   pend_data;
  logic [NUM_DIGITS-1:0]     pend_dp;
  logic                      pend_v;
  logic [4*NUM_DIGITS-1:0]   act_data;
  logic [NUM_DIGITS-1:0]     act_dp;

  logic       cnt_wrap;
  logic       boundary;
  logic       accept;
  logic       commit;
  logic [3:0] cur_nib;
  logic       cur_dp;
  seg_t       dec_seg;
  seg_t       lit_seg;

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign boundary   = scan_en && cnt_wrap && (idx == 2'd2);
  assign frame_tick = boundary;

  // Handshake: a value transfers on any cycle with wr_valid && wr_ready. wr_ready is
  // simply "pending slot empty", so it drops the cycle after an accept and rises the
  // cycle after the pending value moves to the active register. Accept and commit are
  // mutually exclusive because one needs the slot empty and the other needs it full.
  assign wr_ready = ~pend_v;
  assign accept   = wr_valid && !pend_v;
  // With scanning stopped nothing is on screen, so a pending value may commit at once.
  assign commit   = pend_v && (boundary || !scan_en);

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (!scan_en) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Pending / active value registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_v    <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
    end else if (accept) begin
      pend_data <= wr_data;
      pend_dp   <= wr_dp;
      pend_v    <= 1'b1;
    end else if (commit) begin
      act_data  <= pend_data;
      act_dp    <= pend_dp;
      pend_v    <= 1'b0;
    end
  end

  // Select the nibble and decimal point of the digit being scanned
  always_comb begin
    cur_nib = act_data[3:0];
    cur_dp  = act_dp[0];
    case (idx)
      2'd1: begin
        cur_nib = act_data[7:4];
        cur_dp  = act_dp[1];
      end
      2'd2: begin
        cur_nib = act_data[11:8];
        cur_dp  = act_dp[2];
      end
      default: ;
    endcase
  end

  sevenseg_hex_dec u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

`ifdef SEVSEG_LZB_EN
  // A leading zero keeps its enable and dwell but lights no a..g segments; dp still shows.
  logic lz_blank;
  assign lz_blank = ((idx == 2'd2) && (act_data[11:8] == 4'd0)) ||
                    ((idx == 2'd1) && (act_data[11:4] == 8'd0));
  assign lit_seg  = lz_blank ? {7'b1111111, dec_seg[0]} : dec_seg;
`else
  assign lit_seg  = dec_seg;
`endif

  // Registered pin drivers: they show the cnt/idx of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_BLANK;
      seg_en <= '1;
    end else if (!scan_en || (cnt < CNT_BLANK)) begin
      seg    <= SEG_BLANK;
      seg_en <= '1;
    end else begin
      seg    <= lit_seg;
      seg_en <= ~(3'b001 << idx);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl
//   Directed bench for sevenseg_scan_ctrl with SCAN_DIV = 8, BLANK_CYC = 2.
//   n counts rising edges since reset release; outputs are sampled 1 time unit after
//   each edge, and inputs for the next edge are driven at the same point.
//   Build option: SEVSEG_LZB_EN switches the expectations for leading-zero blanking.
module tb_sevenseg_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int DIV_W     = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_data;
  logic [2:0]  wr_dp;
  logic [7:0]  seg;
  logic [2:0]  seg_en;
  logic        frame_tick;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .DIV_W     (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .seg        (seg),
    .seg_en     (seg_en),
    .frame_tick (frame_tick)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n;
  int checks;
  int errors;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, expv);
    end
  endtask

  task automatic chk_outputs(input logic [2:0] e_en, input logic [7:0] e_seg,
                             input logic e_rdy, input logic e_tick);
    exp_q.push_back({5'd0, e_en});
    exp_q.push_back(e_seg);
    exp_q.push_back({7'd0, e_rdy});
    exp_q.push_back({7'd0, e_tick});
    chk("seg_en", {5'd0, seg_en}, exp_q.pop_front());
    chk("seg", seg, exp_q.pop_front());
    chk("wr_ready", {7'd0, wr_ready}, exp_q.pop_front());
    chk("frame_tick", {7'd0, frame_tick}, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int target);
    while (n < target) step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic        scan_en;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic [2:0]  wr_dp;
    logic [2:0]  exp_en;
    logic [7:0]  exp_seg;
    logic        exp_ready;
    logic        exp_tick;
    logic        lz;        // digit shown here is a leading zero
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int vn, logic se, logic v, logic [11:0] d, logic [2:0] dp,
                              logic [2:0] e_en, logic [7:0] e_seg, logic e_rdy,
                              logic e_tick, logic lz);
    vec_t r;
    r.n = vn; r.scan_en = se; r.wr_valid = v; r.wr_data = d; r.wr_dp = dp;
    r.exp_en = e_en; r.exp_seg = e_seg; r.exp_ready = e_rdy; r.exp_tick = e_tick; r.lz = lz;
    vecs.push_back(r);
  endfunction

  function automatic logic [7:0] lz_adj(logic [7:0] s, logic lz);
    logic [7:0] r;
    r = s;
`ifdef SEVSEG_LZB_EN
    if (lz) r = {7'b1111111, s[0]};
`endif
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    n = 0;

    // Free-running scan of the reset value 000
    add(  0, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(  1, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(  2, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(  3, 1, 0, 12'h000, 3'b000, 3'b110, 8'h03, 1, 0, 0);
    add(  8, 1, 0, 12'h000, 3'b000, 3'b110, 8'h03, 1, 0, 0);
    add(  9, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add( 11, 1, 0, 12'h000, 3'b000, 3'b101, 8'h03, 1, 0, 1);
    add( 17, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add( 19, 1, 0, 12'h000, 3'b000, 3'b011, 8'h03, 1, 0, 1);
    add( 23, 1, 0, 12'h000, 3'b000, 3'b011, 8'h03, 1, 1, 1);
    add( 24, 1, 0, 12'h000, 3'b000, 3'b011, 8'h03, 1, 0, 1);
    add( 25, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add( 27, 1, 0, 12'h000, 3'b000, 3'b110, 8'h03, 1, 0, 0);
    // Mid-frame write A5C/010, then a second offer (123) held while not ready
    add( 30, 1, 1, 12'hA5C, 3'b010, 3'b110, 8'h03, 1, 0, 0);
    add( 31, 1, 1, 12'h123, 3'b000, 3'b110, 8'h03, 0, 0, 0);
    add( 47, 1, 1, 12'h123, 3'b000, 3'b011, 8'h03, 0, 1, 1);
    add( 48, 1, 1, 12'h123, 3'b000, 3'b011, 8'h03, 1, 0, 1);
    add( 49, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 0, 0, 0);
    add( 51, 1, 0, 12'h000, 3'b000, 3'b110, 8'h63, 0, 0, 0);
    add( 59, 1, 0, 12'h000, 3'b000, 3'b101, 8'h48, 0, 0, 0);
    add( 67, 1, 0, 12'h000, 3'b000, 3'b011, 8'h11, 0, 0, 0);
    add( 71, 1, 0, 12'h000, 3'b000, 3'b011, 8'h11, 0, 1, 0);
    add( 72, 1, 0, 12'h000, 3'b000, 3'b011, 8'h11, 1, 0, 0);
    add( 75, 1, 0, 12'h000, 3'b000, 3'b110, 8'h0D, 1, 0, 0);
    add( 83, 1, 0, 12'h000, 3'b000, 3'b101, 8'h25, 1, 0, 0);
    add( 91, 1, 0, 12'h000, 3'b000, 3'b011, 8'h9F, 1, 0, 0);
    // Write FED/111 on the exact boundary cycle: skips one frame
    add( 95, 1, 1, 12'hFED, 3'b111, 3'b011, 8'h9F, 1, 1, 0);
    add( 96, 1, 0, 12'h000, 3'b000, 3'b011, 8'h9F, 0, 0, 0);
    add( 99, 1, 0, 12'h000, 3'b000, 3'b110, 8'h0D, 0, 0, 0);
    add(107, 1, 0, 12'h000, 3'b000, 3'b101, 8'h25, 0, 0, 0);
    add(115, 1, 0, 12'h000, 3'b000, 3'b011, 8'h9F, 0, 0, 0);
    add(119, 1, 0, 12'h000, 3'b000, 3'b011, 8'h9F, 0, 1, 0);
    add(120, 1, 0, 12'h000, 3'b000, 3'b011, 8'h9F, 1, 0, 0);
    add(123, 1, 0, 12'h000, 3'b000, 3'b110, 8'h84, 1, 0, 0);
    add(131, 1, 0, 12'h000, 3'b000, 3'b101, 8'h60, 1, 0, 0);
    add(139, 1, 0, 12'h000, 3'b000, 3'b011, 8'h70, 1, 0, 0);
    // Write 456 then drop scan_en mid-digit-1: blank + immediate commit, then restart
    add(150, 1, 1, 12'h456, 3'b000, 3'b110, 8'h84, 1, 0, 0);
    add(151, 1, 0, 12'h000, 3'b000, 3'b110, 8'h84, 0, 0, 0);
    add(155, 0, 0, 12'h000, 3'b000, 3'b101, 8'h60, 0, 0, 0);
    add(156, 0, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(160, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(161, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(162, 1, 0, 12'h000, 3'b000, 3'b111, 8'hFF, 1, 0, 0);
    add(163, 1, 0, 12'h000, 3'b000, 3'b110, 8'h41, 1, 0, 0);
    add(171, 1, 0, 12'h000, 3'b000, 3'b101, 8'h49, 1, 0, 0);

    // Reset block
    rst_n    = 1'b0;
    scan_en  = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 12'h000;
    wr_dp    = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;

    foreach (vecs[i]) begin
      step_to(vecs[i].n);
      chk_outputs(vecs[i].exp_en, lz_adj(vecs[i].exp_seg, vecs[i].lz),
                  vecs[i].exp_ready, vecs[i].exp_tick);
      scan_en  = vecs[i].scan_en;
      wr_valid = vecs[i].wr_valid;
      wr_data  = vecs[i].wr_data;
      wr_dp    = vecs[i].wr_dp;
    end

    // Reset mid-frame with a value (789) pending
    wr_valid = 1'b1;
    wr_data  = 12'h789;
    wr_dp    = 3'b000;
    step();
    wr_valid = 1'b0;
    chk("pend_ready", {7'd0, wr_ready}, 8'h00);
    step();
    step();
    chk("pre_rst_seg_en", {5'd0, seg_en}, 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs(3'b111, 8'hFF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_outputs(3'b111, 8'hFF, 1'b1, 1'b0);
    rst_n = 1'b1;
    n = 0;
    // Active value must be back to 000 and the 789 write lost
    step_to(3);
    chk_outputs(3'b110, 8'h03, 1'b1, 1'b0);

    // Write 007 and watch leading-zero handling in the following frame
    wr_valid = 1'b1;
    wr_data  = 12'h007;
    wr_dp    = 3'b000;
    step();
    wr_valid = 1'b0;
    chk("lzb_ready", {7'd0, wr_ready}, 8'h00);
    step_to(23);
    chk_outputs(3'b011, lz_adj(8'h03, 1'b1), 1'b0, 1'b1);
    step_to(24);
    chk("commit_ready", {7'd0, wr_ready}, 8'h01);
    step_to(27);
    chk_outputs(3'b110, 8'h1F, 1'b1, 1'b0);
    step_to(35);
    chk_outputs(3'b101, lz_adj(8'h03, 1'b1), 1'b1, 1'b0);
    step_to(43);
    chk_outputs(3'b011, lz_adj(8'h03, 1'b1), 1'b1, 1'b0);
    step_to(47);
    chk("frame2_tick", {7'd0, frame_tick}, 8'h01);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
